mac_array_feeder: RTL and testbench
===================================

# mac_array_feeder

Operand sequencer that drives the input side of the 8-lane MAC array. It receives a 128-bit weight stream and a 128-bit activation stream over valid/ready handshakes. It assembles eight weight lanes and eight data lanes, then issues them as one single-cycle valid beat. Weights stay resident for REUSE consecutive issues before the next weight set is loaded. The block sits between the operand buffers and the MAC array.

## Interface
- REUSE, 4: number of issues per loaded weight set (1..65535)
- LANES, 8: lanes per operand set (fixed at 8; kept as a parameter for the package constant)
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- clear_i  in  1  synchronous abort; discard the partial set and return to weight load
- wgt_vld_i  in  1  weight beat valid
- wgt_rdy_o  out  1  weight beat ready
- wgt_data_i  in  128  weight beat (16 x int8)
- din_vld_i  in  1  activation beat valid
- din_rdy_o  out  1  activation beat ready
- din_data_i  in  128  activation beat
- win_0..win_7  out  128 each  weight lanes to the MAC array
- din_0..din_7  out  128 each  data lanes to the MAC array
- vld_o  out  1  one-cycle issue strobe (drives MAC array vld_i)
- issue_cnt_o  out  32  total issues (performance)
- stall_cnt_o  out  32  cycles stalled in data load with din_vld_i low (performance)

## Operation
- The state register takes one of three values: S_WLOAD, S_DLOAD, S_ISSUE. Reset state is S_WLOAD.
- wgt_rdy_o = (state==S_WLOAD); din_rdy_o = (state==S_DLOAD). Both are decoded from the state register only and never depend on the valid inputs. Both are 0 while rst=1.
- A beat transfers on vld & rdy at a clock edge.
- Lane counter lane_q (3 bits) is shared by both load phases.
  - Beat k writes win_k (in S_WLOAD) or din_k (in S_DLOAD), then lane_q increments.
  - The transfer at lane_q==7 clears lane_q and advances the state.
- S_WLOAD: on the 8th beat, go to S_DLOAD and set reuse_q=0.
- S_DLOAD: on the 8th beat, go to S_ISSUE.
- S_ISSUE: vld_o=1 for exactly this cycle.
  - If reuse_q==REUSE-1, go to S_WLOAD.
  - Otherwise reuse_q+1 and go to S_DLOAD.
- Lane registers hold their value until overwritten. The downstream array samples all lanes in the vld_o cycle. Later overwrites during the next load are legal.
- clear_i has priority over any transfer in the same cycle:
  - state goes to S_WLOAD; lane_q and reuse_q go to 0.
  - Lane contents are unchanged.
  - vld_o is not asserted in the cycle after a clear.
  - A beat presented with rdy=1 in the clear cycle is not consumed.
- rst has priority over clear_i.
- Reset values: all win_k/din_k = 0, vld_o=0, issue_cnt_o=0, stall_cnt_o=0, lane_q=0, reuse_q=0.
- The counters wrap modulo 2^32.
  - issue_cnt_o increments in each S_ISSUE cycle.
  - stall_cnt_o increments in each S_DLOAD cycle with din_vld_i=0.
  - clear_i does not reset the counters.

## Timing
- All outputs are registered. vld_o is a state decode of a registered state.
- Steady state (REUSE>1, no stalls): 8 data cycles + 1 issue cycle gives one issue every 9 cycles.
- A weight reload adds 8 cycles.
- Latency: vld_o is high in the cycle immediately after the edge that accepted the 8th data beat.
- Sources may hold vld asserted across rdy=0 cycles. Data must be stable while vld=1 and rdy=0.

## Configuration
- MAC_FEEDER_PERF_EN defined: issue_cnt_o and stall_cnt_o are implemented as specified.
- MAC_FEEDER_PERF_EN undefined: the counter registers are removed, and both ports are tied to 32'd0. The port list is identical in both builds.

## Structure
- Shared package mac_feeder_pkg holds:
  - the state enum S_WLOAD/S_DLOAD/S_ISSUE;
  - LANE_W=128 and LANES=8;
  - CNT_W=32.
- One natural sub-module: mac_feeder_lane_bank. It is an 8 x 128 register bank with a write enable and a 3-bit write index, driving eight outputs. It is instantiated twice, once for weights and once for data.

## Test plan
- Reset, REUSE=1: load weights 0x01..0x08 (byte-replicated per lane) and data 0x10..0x17.
  - vld_o pulses once, in the cycle after the 8th data beat.
  - win_3=16{0x04}, din_7=16{0x17}.
  - wgt_rdy_o=1 in the next cycle.
- REUSE=4, continuous valids: after one weight load, exactly 4 vld_o pulses spaced 9 cycles apart. Weight lanes are unchanged across all 4 issues. wgt_rdy_o returns after the 4th pulse.
- Backpressure: toggle din_vld_i every cycle during the data load.
  - Issue occurs 16 cycles after entering S_DLOAD.
  - stall_cnt_o=8 (PERF build), or 0 in the non-PERF build.
- clear_i asserted with the 5th data beat (lane_q=4):
  - the beat is not consumed;
  - state is S_WLOAD next cycle;
  - no vld_o;
  - a fresh load issues with the new data.
- rst asserted mid S_DLOAD: all outputs 0 in the next cycle and wgt_rdy_o=0 while rst=1. After release, wgt_rdy_o=1.
- Run 3 weight sets x REUSE=4: issue_cnt_o=12 and vld_o count=12.

Source files
------------

// File: rtl/mac_feeder_pkg.sv
// mac_feeder_pkg
// Shared types and constants for the MAC array operand feeder.
//   feeder_state_t : sequencer state (weight load, data load, issue)
//   LANE_W         : width of one operand lane (16 x int8)
//   LANES          : operand lanes per set
//   CNT_W          : width of the performance counters
//   lane_t         : one operand lane
package mac_feeder_pkg;

    localparam int LANE_W = 128;
    localparam int LANES  = 8;
    localparam int CNT_W  = 32;

    typedef enum logic [1:0] {
        S_WLOAD = 2'd0,
        S_DLOAD = 2'd1,
        S_ISSUE = 2'd2
    } feeder_state_t;

    typedef logic [LANE_W-1:0] lane_t;

endpackage

// File: rtl/mac_feeder_lane_bank.sv
// mac_feeder_lane_bank
// Eight-entry operand register bank. One entry is written per cycle when
// i_we is high; all entries are presented in parallel to the MAC array.
// Entries hold their value until overwritten and clear to zero on reset.
//   clk       : clock
//   rst       : synchronous active-high reset
//   i_we      : write enable
//   i_idx     : entry to write
//   i_data    : value written
//   o_lane_0..o_lane_7 : registered entry contents
module mac_feeder_lane_bank
    import mac_feeder_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_we,
    input  logic [2:0]  i_idx,
    input  lane_t       i_data,
    output lane_t       o_lane_0,
    output lane_t       o_lane_1,
    output lane_t       o_lane_2,
    output lane_t       o_lane_3,
    output lane_t       o_lane_4,
    output lane_t       o_lane_5,
    output lane_t       o_lane_6,
    output lane_t       o_lane_7
);

    lane_t r_bank [LANES];

    // Storage: only the addressed entry is updated, the rest keep their value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LANES; i++) begin
                r_bank[i] <= '0;
            end
        end else if (i_we) begin
            r_bank[i_idx] <= i_data;
        end
    end

    assign o_lane_0 = r_bank[0];
    assign o_lane_1 = r_bank[1];
    assign o_lane_2 = r_bank[2];
    assign o_lane_3 = r_bank[3];
    assign o_lane_4 = r_bank[4];
    assign o_lane_5 = r_bank[5];
    assign o_lane_6 = r_bank[6];
    assign o_lane_7 = r_bank[7];

endmodule

// File: rtl/mac_array_feeder.sv
// mac_array_feeder
// Operand sequencer for the 8-lane MAC array. Collects eight weight beats,
// then eight activation beats, and issues both sets as a one-cycle vld_o
// strobe. The weight set is reused for REUSE issues before a reload.
//   clk, rst              : clock, synchronous active-high reset
//   clear_i               : abort the current set and return to weight load
//   wgt_vld_i/wgt_rdy_o/wgt_data_i : weight beat handshake and payload
//   din_vld_i/din_rdy_o/din_data_i : activation beat handshake and payload
//   win_0..win_7, din_0..din_7     : operand lanes to the MAC array
//   vld_o                 : issue strobe
//   issue_cnt_o, stall_cnt_o : performance counters
// Build option: define MAC_FEEDER_PERF_EN to implement the performance
// counters; otherwise both counter ports read as zero.
module mac_array_feeder
    import mac_feeder_pkg::*;
#(
    parameter int REUSE = 4,
    parameter int LANES = mac_feeder_pkg::LANES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              wgt_vld_i,
    output logic              wgt_rdy_o,
    input  lane_t             wgt_data_i,
    input  logic              din_vld_i,
    output logic              din_rdy_o,
    input  lane_t             din_data_i,
    output lane_t             win_0,
    output lane_t             win_1,
    output lane_t             win_2,
    output lane_t             win_3,
    output lane_t             win_4,
    output lane_t             win_5,
    output lane_t             win_6,
    output lane_t             win_7,
    output lane_t             din_0,
    output lane_t             din_1,
    output lane_t             din_2,
    output lane_t             din_3,
    output lane_t             din_4,
    output lane_t             din_5,
    output lane_t             din_6,
    output lane_t             din_7,
    output logic              vld_o,
    output logic [CNT_W-1:0]  issue_cnt_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam int LIDX_W = $clog2(LANES);

    feeder_state_t      r_state;
    feeder_state_t      w_nextState;
    logic [LIDX_W-1:0]  r_lane;
    logic [LIDX_W-1:0]  w_nextLane;
    logic [15:0]        r_reuse;
    logic [15:0]        w_nextReuse;
    logic               r_wgtRdy;
    logic               r_dinRdy;
    logic               w_wgtXfer;
    logic               w_dinXfer;
    logic               w_lastLane;
    logic               w_wgtWe;
    logic               w_dinWe;
    logic               w_issue;

    assign w_wgtXfer  = wgt_vld_i & r_wgtRdy;
    assign w_dinXfer  = din_vld_i & r_dinRdy;
    assign w_lastLane = (r_lane == LIDX_W'(LANES - 1));

    // State register. The ready flags are registered copies of the next-state
    // decode so they track the state exactly, yet are held low for as long as
    // rst is asserted (the state itself already sits in S_WLOAD by then).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_WLOAD;
            r_lane   <= '0;
            r_reuse  <= '0;
            r_wgtRdy <= 1'b0;
            r_dinRdy <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_lane   <= w_nextLane;
            r_reuse  <= w_nextReuse;
            r_wgtRdy <= (w_nextState == S_WLOAD);
            r_dinRdy <= (w_nextState == S_DLOAD);
        end
    end

    // Next-state logic. clear_i wins over any transfer in the same cycle, and
    // the lane counter is shared by both load phases.
    always_comb begin
        w_nextState = r_state;
        w_nextLane  = r_lane;
        w_nextReuse = r_reuse;
        if (clear_i) begin
            w_nextState = S_WLOAD;
            w_nextLane  = '0;
            w_nextReuse = '0;
        end else begin
            case (r_state)
                S_WLOAD: begin
                    if (w_wgtXfer) begin
                        if (w_lastLane) begin
                            w_nextState = S_DLOAD;
                            w_nextLane  = '0;
                            w_nextReuse = '0;
                        end else begin
                            w_nextLane = r_lane + LIDX_W'(1);
                        end
                    end
                end
                S_DLOAD: begin
                    if (w_dinXfer) begin
                        if (w_lastLane) begin
                            w_nextState = S_ISSUE;
                            w_nextLane  = '0;
                        end else begin
                            w_nextLane = r_lane + LIDX_W'(1);
                        end
                    end
                end
                S_ISSUE: begin
                    if (r_reuse == 16'(REUSE - 1)) begin
                        w_nextState = S_WLOAD;
                    end else begin
                        w_nextState = S_DLOAD;
                        w_nextReuse = r_reuse + 16'd1;
                    end
                end
                default: begin
                    w_nextState = S_WLOAD;
                    w_nextLane  = '0;
                    w_nextReuse = '0;
                end
            endcase
        end
    end

    // Output decode. A beat offered alongside clear_i must not land in a lane.
    always_comb begin
        w_wgtWe = w_wgtXfer & ~clear_i;
        w_dinWe = w_dinXfer & ~clear_i;
        w_issue = (r_state == S_ISSUE);
    end

    assign wgt_rdy_o = r_wgtRdy;
    assign din_rdy_o = r_dinRdy;
    assign vld_o     = w_issue;

    mac_feeder_lane_bank u_wgtBank (
        .clk      (clk),
        .rst      (rst),
        .i_we     (w_wgtWe),
        .i_idx    (r_lane),
        .i_data   (wgt_data_i),
        .o_lane_0 (win_0),
        .o_lane_1 (win_1),
        .o_lane_2 (win_2),
        .o_lane_3 (win_3),
        .o_lane_4 (win_4),
        .o_lane_5 (win_5),
        .o_lane_6 (win_6),
        .o_lane_7 (win_7)
    );

    mac_feeder_lane_bank u_dinBank (
        .clk      (clk),
        .rst      (rst),
        .i_we     (w_dinWe),
        .i_idx    (r_lane),
        .i_data   (din_data_i),
        .o_lane_0 (din_0),
        .o_lane_1 (din_1),
        .o_lane_2 (din_2),
        .o_lane_3 (din_3),
        .o_lane_4 (din_4),
        .o_lane_5 (din_5),
        .o_lane_6 (din_6),
        .o_lane_7 (din_7)
    );

`ifdef MAC_FEEDER_PERF_EN
    logic [CNT_W-1:0] r_issueCnt;
    logic [CNT_W-1:0] r_stallCnt;

    // Performance counters wrap freely and survive clear_i; only rst zeroes them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_issueCnt <= '0;
            r_stallCnt <= '0;
        end else begin
            if (r_state == S_ISSUE) begin
                r_issueCnt <= r_issueCnt + CNT_W'(1);
            end
            if ((r_state == S_DLOAD) && !din_vld_i) begin
                r_stallCnt <= r_stallCnt + CNT_W'(1);
            end
        end
    end

    assign issue_cnt_o = r_issueCnt;
    assign stall_cnt_o = r_stallCnt;
`else
    assign issue_cnt_o = '0;
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_mac_array_feeder.sv
// tb_mac_array_feeder
// Directed bench for mac_array_feeder. Instance dut runs with REUSE=4 and
// instance dut1 with REUSE=1; both share the same stimulus. Inputs are
// driven and outputs sampled on the falling clock edge.
// Counter expectations follow the MAC_FEEDER_PERF_EN build option.
module tb_mac_array_feeder;

    logic         clk;
    logic         rst;
    logic         clear_i;
    logic         wgt_vld_i;
    logic [127:0] wgt_data_i;
    logic         din_vld_i;
    logic [127:0] din_data_i;

    logic         aWgtRdy, aDinRdy, aVld;
    logic [127:0] aWin [8];
    logic [127:0] aDin [8];
    logic [31:0]  aIssueCnt, aStallCnt;

    logic         bWgtRdy, bDinRdy, bVld;
    logic [127:0] bWin [8];
    logic [127:0] bDin [8];
    logic [31:0]  bIssueCnt, bStallCnt;

    int checks = 0;
    int errors = 0;
    int vldCount = 0;
    bit monEn = 1'b0;

`ifdef MAC_FEEDER_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    mac_array_feeder #(.REUSE(4)) dut (
        .clk(clk), .rst(rst), .clear_i(clear_i),
        .wgt_vld_i(wgt_vld_i), .wgt_rdy_o(aWgtRdy), .wgt_data_i(wgt_data_i),
        .din_vld_i(din_vld_i), .din_rdy_o(aDinRdy), .din_data_i(din_data_i),
        .win_0(aWin[0]), .win_1(aWin[1]), .win_2(aWin[2]), .win_3(aWin[3]),
        .win_4(aWin[4]), .win_5(aWin[5]), .win_6(aWin[6]), .win_7(aWin[7]),
        .din_0(aDin[0]), .din_1(aDin[1]), .din_2(aDin[2]), .din_3(aDin[3]),
        .din_4(aDin[4]), .din_5(aDin[5]), .din_6(aDin[6]), .din_7(aDin[7]),
        .vld_o(aVld), .issue_cnt_o(aIssueCnt), .stall_cnt_o(aStallCnt)
    );

    mac_array_feeder #(.REUSE(1)) dut1 (
        .clk(clk), .rst(rst), .clear_i(clear_i),
        .wgt_vld_i(wgt_vld_i), .wgt_rdy_o(bWgtRdy), .wgt_data_i(wgt_data_i),
        .din_vld_i(din_vld_i), .din_rdy_o(bDinRdy), .din_data_i(din_data_i),
        .win_0(bWin[0]), .win_1(bWin[1]), .win_2(bWin[2]), .win_3(bWin[3]),
        .win_4(bWin[4]), .win_5(bWin[5]), .win_6(bWin[6]), .win_7(bWin[7]),
        .din_0(bDin[0]), .din_1(bDin[1]), .din_2(bDin[2]), .din_3(bDin[3]),
        .din_4(bDin[4]), .din_5(bDin[5]), .din_6(bDin[6]), .din_7(bDin[7]),
        .vld_o(bVld), .issue_cnt_o(bIssueCnt), .stall_cnt_o(bStallCnt)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent count of issue strobes seen on the REUSE=4 instance.
    always @(negedge clk) begin
        if (monEn && aVld === 1'b1) vldCount++;
    end

    // Synchronous reset pulse; returns at the falling edge where weight load is open.
    task automatic doReset();
        rst = 1'b1; clear_i = 1'b0; wgt_vld_i = 1'b0; din_vld_i = 1'b0;
        wgt_data_i = '0; din_data_i = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Feeds eight weight beats, lane k carrying byte base+k replicated.
    task automatic loadWeights(input logic [7:0] base);
        int k = 0;
        int guard = 0;
        while (k < 8 && guard < 64) begin
            wgt_vld_i  = 1'b1;
            wgt_data_i = {16{base + 8'(k)}};
            if (aWgtRdy === 1'b1) k++;
            @(negedge clk);
            guard++;
        end
        wgt_vld_i = 1'b0;
        checks++;
        if (k != 8) begin
            errors++;
            $display("[TB] FAIL weight_load_timeout: beats %0d, required 8", k);
        end
    endtask

    // Feeds eight data beats; returns at the falling edge of the issue cycle.
    task automatic loadData(input logic [7:0] base);
        int k = 0;
        int guard = 0;
        while (k < 8 && guard < 64) begin
            din_vld_i  = 1'b1;
            din_data_i = {16{base + 8'(k)}};
            if (aDinRdy === 1'b1) k++;
            @(negedge clk);
            guard++;
        end
        din_vld_i = 1'b0;
        checks++;
        if (k != 8) begin
            errors++;
            $display("[TB] FAIL data_load_timeout: beats %0d, required 8", k);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; clear_i = 1'b0; wgt_vld_i = 1'b1; din_vld_i = 1'b1;
        wgt_data_i = {16{8'hEE}}; din_data_i = {16{8'hDD}};
        @(negedge clk);
        @(negedge clk);
        checks += 6;
        if (aWgtRdy !== 1'b0) begin errors++; $display("[TB] FAIL reset_wgt_rdy: got %b, want 0", aWgtRdy); end
        if (aDinRdy !== 1'b0) begin errors++; $display("[TB] FAIL reset_din_rdy: got %b, want 0", aDinRdy); end
        if (aVld !== 1'b0) begin errors++; $display("[TB] FAIL reset_vld: got %b, want 0", aVld); end
        if (aWin[5] !== '0) begin errors++; $display("[TB] FAIL reset_win5: got %h, want 0", aWin[5]); end
        if (aDin[2] !== '0) begin errors++; $display("[TB] FAIL reset_din2: got %h, want 0", aDin[2]); end
        if (aIssueCnt !== 32'd0 || aStallCnt !== 32'd0) begin
            errors++; $display("[TB] FAIL reset_counters: got %0d/%0d, want 0/0", aIssueCnt, aStallCnt);
        end
        rst = 1'b0; wgt_vld_i = 1'b0; din_vld_i = 1'b0;
        @(negedge clk);
        checks++;
        if (aWgtRdy !== 1'b1) begin errors++; $display("[TB] FAIL release_wgt_rdy: got %b, want 1", aWgtRdy); end
    endtask

    task automatic test_single_issue();
        doReset();
        loadWeights(8'h01);
        loadData(8'h10);
        checks += 3;
        if (bVld !== 1'b1) begin errors++; $display("[TB] FAIL r1_vld_issue: got %b, want 1", bVld); end
        if (bWin[3] !== {16{8'h04}}) begin errors++; $display("[TB] FAIL r1_win3: got %h, want %h", bWin[3], {16{8'h04}}); end
        if (bDin[7] !== {16{8'h17}}) begin errors++; $display("[TB] FAIL r1_din7: got %h, want %h", bDin[7], {16{8'h17}}); end
        @(negedge clk);
        checks += 2;
        if (bVld !== 1'b0) begin errors++; $display("[TB] FAIL r1_vld_once: got %b, want 0", bVld); end
        if (bWgtRdy !== 1'b1) begin errors++; $display("[TB] FAIL r1_wgt_rdy_after: got %b, want 1", bWgtRdy); end
    endtask

    task automatic test_reuse();
        int pulses = 0;
        logic expVld;
        doReset();
        loadWeights(8'h81);
        for (int c = 0; c < 40; c++) begin
            din_vld_i  = 1'b1;
            din_data_i = {16{8'hA0 + 8'(c)}};
            expVld = (c == 8 || c == 17 || c == 26 || c == 35);
            checks++;
            if (aVld !== expVld) begin
                errors++; $display("[TB] FAIL reuse_vld_c%0d: got %b, want %b", c, aVld, expVld);
            end
            if (expVld) begin
                pulses++;
                checks += 2;
                if (aWin[0] !== {16{8'h81}}) begin errors++; $display("[TB] FAIL reuse_win0_p%0d: got %h, want %h", pulses, aWin[0], {16{8'h81}}); end
                if (aWin[7] !== {16{8'h88}}) begin errors++; $display("[TB] FAIL reuse_win7_p%0d: got %h, want %h", pulses, aWin[7], {16{8'h88}}); end
            end
            if (c == 36) begin
                checks++;
                if (aWgtRdy !== 1'b1) begin errors++; $display("[TB] FAIL reuse_wgt_rdy_return: got %b, want 1", aWgtRdy); end
            end
            @(negedge clk);
        end
        din_vld_i = 1'b0;
    endtask

    task automatic test_backpressure();
        doReset();
        loadWeights(8'h31);
        for (int c = 0; c < 16; c++) begin
            din_vld_i  = c[0];
            din_data_i = {16{8'h40 + 8'(c / 2)}};
            checks++;
            if (aVld !== 1'b0) begin errors++; $display("[TB] FAIL bp_early_vld_c%0d: got %b, want 0", c, aVld); end
            @(negedge clk);
        end
        din_vld_i = 1'b0;
        checks += 3;
        if (aVld !== 1'b1) begin errors++; $display("[TB] FAIL bp_issue_at_16: got %b, want 1", aVld); end
        if (aDin[3] !== {16{8'h43}}) begin errors++; $display("[TB] FAIL bp_din3: got %h, want %h", aDin[3], {16{8'h43}}); end
        if (aStallCnt !== (PERF ? 32'd8 : 32'd0)) begin
            errors++; $display("[TB] FAIL bp_stall_cnt: got %0d, want %0d", aStallCnt, PERF ? 8 : 0);
        end
    endtask

    task automatic test_clear();
        doReset();
        loadWeights(8'h01);
        for (int i = 0; i < 4; i++) begin
            din_vld_i  = 1'b1;
            din_data_i = {16{8'h50 + 8'(i)}};
            @(negedge clk);
        end
        din_data_i = {16{8'h54}};
        clear_i    = 1'b1;
        @(negedge clk);
        clear_i   = 1'b0;
        din_vld_i = 1'b0;
        checks += 5;
        if (aWgtRdy !== 1'b1) begin errors++; $display("[TB] FAIL clr_wgt_rdy: got %b, want 1", aWgtRdy); end
        if (aDinRdy !== 1'b0) begin errors++; $display("[TB] FAIL clr_din_rdy: got %b, want 0", aDinRdy); end
        if (aVld !== 1'b0) begin errors++; $display("[TB] FAIL clr_vld: got %b, want 0", aVld); end
        if (aDin[4] !== '0) begin errors++; $display("[TB] FAIL clr_beat_consumed: got %h, want 0", aDin[4]); end
        if (aDin[3] !== {16{8'h53}}) begin errors++; $display("[TB] FAIL clr_din3_kept: got %h, want %h", aDin[3], {16{8'h53}}); end
        loadWeights(8'h61);
        loadData(8'h70);
        checks += 3;
        if (aVld !== 1'b1) begin errors++; $display("[TB] FAIL clr_fresh_vld: got %b, want 1", aVld); end
        if (aDin[4] !== {16{8'h74}}) begin errors++; $display("[TB] FAIL clr_fresh_din4: got %h, want %h", aDin[4], {16{8'h74}}); end
        if (aWin[7] !== {16{8'h68}}) begin errors++; $display("[TB] FAIL clr_fresh_win7: got %h, want %h", aWin[7], {16{8'h68}}); end
    endtask

    task automatic test_reset_mid_load();
        doReset();
        loadWeights(8'h11);
        for (int i = 0; i < 3; i++) begin
            din_vld_i  = 1'b1;
            din_data_i = {16{8'h90 + 8'(i)}};
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        checks += 5;
        if (aWgtRdy !== 1'b0 || aDinRdy !== 1'b0) begin
            errors++; $display("[TB] FAIL rst_mid_rdy: got %b/%b, want 0/0", aWgtRdy, aDinRdy);
        end
        if (aVld !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_vld: got %b, want 0", aVld); end
        if (aWin[0] !== '0) begin errors++; $display("[TB] FAIL rst_mid_win0: got %h, want 0", aWin[0]); end
        if (aDin[1] !== '0) begin errors++; $display("[TB] FAIL rst_mid_din1: got %h, want 0", aDin[1]); end
        if (aStallCnt !== 32'd0) begin errors++; $display("[TB] FAIL rst_mid_stall: got %0d, want 0", aStallCnt); end
        @(negedge clk);
        checks++;
        if (aWgtRdy !== 1'b0) begin errors++; $display("[TB] FAIL rst_hold_wgt_rdy: got %b, want 0", aWgtRdy); end
        rst = 1'b0;
        din_vld_i = 1'b0;
        @(negedge clk);
        checks++;
        if (aWgtRdy !== 1'b1) begin errors++; $display("[TB] FAIL rst_release_wgt_rdy: got %b, want 1", aWgtRdy); end
    endtask

    task automatic test_back_to_back();
        doReset();
        vldCount = 0;
        monEn = 1'b1;
        for (int s = 0; s < 3; s++) begin
            loadWeights(8'h20 * 8'(s + 1));
            for (int r = 0; r < 4; r++) begin
                loadData(8'hC0 + 8'(r * 8));
            end
        end
        @(negedge clk);
        monEn = 1'b0;
        checks += 2;
        if (vldCount != 12) begin errors++; $display("[TB] FAIL b2b_vld_pulses: got %0d, want 12", vldCount); end
        if (aIssueCnt !== (PERF ? 32'd12 : 32'd0)) begin
            errors++; $display("[TB] FAIL b2b_issue_cnt: got %0d, want %0d", aIssueCnt, PERF ? 12 : 0);
        end
    endtask

    // Test sequence.
    initial begin
        rst = 1'b1; clear_i = 1'b0; wgt_vld_i = 1'b0; din_vld_i = 1'b0;
        wgt_data_i = '0; din_data_i = '0;
        $display("[TB] starting mac_array_feeder bench, PERF=%0d", PERF);
        test_reset();
        test_single_issue();
        test_reuse();
        test_backpressure();
        test_clear();
        test_reset_mid_load();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
